store_buffer: RTL and testbench

//  Collects executed stores (addr, data, RB index) from the store reservation stations and holds

---
 rtl/store_buffer_if.sv | 41 ++++
 rtl/store_buffer.sv | 173 +++++++++++++++++
 tb/tb_store_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer interface: store RS offers, ROB commit/flush, dmem write port,
// completion report and the optional load-forwarding lookup.
interface store_buffer_if #(
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 4,
  parameter int STORER_NUM = 2
);
  logic [STORER_NUM-1:0]           st_valid;
  logic [STORER_NUM*WORD_SIZE-1:0] st_addr;
  logic [STORER_NUM*WORD_SIZE-1:0] st_data;
  logic [STORER_NUM*RB_INDEX-1:0]  st_rb;
  logic [STORER_NUM-1:0]           st_ack;
  logic                            commit_valid;
  logic [RB_INDEX-1:0]             commit_rb;
  logic                            flush;
  logic                            mem_req;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE-1:0]            mem_wdata;
  logic                            mem_ack;
  logic                            done_valid;
  logic [RB_INDEX-1:0]             done_rb;
  logic                            sb_full;
  logic [WORD_SIZE-1:0]            ld_addr;
  logic                            fwd_hit;
  logic [WORD_SIZE-1:0]            fwd_data;
  logic                            fwd_conflict;

  modport master (
    output st_valid, st_addr, st_data, st_rb, commit_valid, commit_rb, flush,
           mem_ack, ld_addr,
    input  st_ack, mem_req, mem_addr, mem_wdata, done_valid, done_rb, sb_full,
           fwd_hit, fwd_data, fwd_conflict
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_rb, commit_valid, commit_rb, flush,
           mem_ack, ld_addr,
    output st_ack, mem_req, mem_addr, mem_wdata, done_valid, done_rb, sb_full,
           fwd_hit, fwd_data, fwd_conflict
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: holds executed stores until the ROB commits them, then drains
// committed entries to dmem one at a time over a req/ack handshake.
// Optional feature macro: STORE_FWD_EN (store-to-load forwarding CAM).
module store_buffer #(
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 4,
  parameter int STORER_NUM = 2,
  parameter int SB_DEPTH   = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);
  localparam int IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int SRC_W = (STORER_NUM > 1) ? $clog2(STORER_NUM) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                state_r, next_state_s;
  logic [SB_DEPTH-1:0]   valid_r, comm_r, valid_n_s, comm_n_s;
  logic [WORD_SIZE-1:0]  addr_r [SB_DEPTH];
  logic [WORD_SIZE-1:0]  data_r [SB_DEPTH];
  logic [RB_INDEX-1:0]   rb_r   [SB_DEPTH];
  logic [WORD_SIZE-1:0]  addr_n_s [SB_DEPTH];
  logic [WORD_SIZE-1:0]  data_n_s [SB_DEPTH];
  logic [RB_INDEX-1:0]   rb_n_s   [SB_DEPTH];
  logic [SB_DEPTH-1:0]   wr_s, retire_s, pend_s;
  logic                  free_found_s, enq_s, pick_found_s;
  logic [IDX_W-1:0]      enq_slot_s, pick_s, sel_r;
  logic [SRC_W-1:0]      enq_src_s;
  logic [STORER_NUM-1:0] ack_s;
  logic [WORD_SIZE-1:0]  enq_addr_s, enq_data_s;
  logic [RB_INDEX-1:0]   enq_rb_s;
  logic                  sb_full_r, mem_req_r, done_valid_r;
  logic [WORD_SIZE-1:0]  mem_addr_r, mem_wdata_r;
  logic [RB_INDEX-1:0]   done_rb_r;

  // Enqueue arbitration: lowest free slot, lowest requesting storer, none on flush.
  always_comb begin
    free_found_s = 1'b0;
    enq_slot_s   = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      free_found_s = free_found_s | ~valid_r[i];
      enq_slot_s   = valid_r[i] ? enq_slot_s : IDX_W'(i);
    end
    enq_s     = 1'b0;
    enq_src_s = '0;
    for (int j = STORER_NUM - 1; j >= 0; j--) begin
      enq_s     = enq_s | sb.st_valid[j];
      enq_src_s = sb.st_valid[j] ? SRC_W'(j) : enq_src_s;
    end
    enq_s = enq_s & free_found_s & ~sb.flush;
    ack_s = '0;
    ack_s[enq_src_s] = enq_s;
    enq_addr_s = sb.st_addr[enq_src_s*WORD_SIZE +: WORD_SIZE];
    enq_data_s = sb.st_data[enq_src_s*WORD_SIZE +: WORD_SIZE];
    enq_rb_s   = sb.st_rb[enq_src_s*RB_INDEX +: RB_INDEX];
  end

  // Next entry state: enqueue, then commit, then flush of uncommitted, then retire.
  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      wr_s[i]     = enq_s && (enq_slot_s == IDX_W'(i));
      retire_s[i] = (state_r == WRITE) && sb.mem_ack && (sel_r == IDX_W'(i));
      addr_n_s[i] = wr_s[i] ? enq_addr_s : addr_r[i];
      data_n_s[i] = wr_s[i] ? enq_data_s : data_r[i];
      rb_n_s[i]   = wr_s[i] ? enq_rb_s   : rb_r[i];
      valid_n_s[i] = valid_r[i] | wr_s[i];
      comm_n_s[i]  = (comm_r[i] & ~wr_s[i]) |
                     (valid_n_s[i] & sb.commit_valid & (rb_n_s[i] == sb.commit_rb));
      valid_n_s[i] = valid_n_s[i] & ~(sb.flush & ~comm_n_s[i]) & ~retire_s[i];
      comm_n_s[i]  = comm_n_s[i] & valid_n_s[i];
    end
    pend_s       = valid_n_s & comm_n_s;
    pick_found_s = |pend_s;
    pick_s       = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      pick_s = pend_s[i] ? IDX_W'(i) : pick_s;
    end
  end

  // Drain FSM next state: start a write when any committed entry exists.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = pick_found_s ? WRITE : IDLE;
      WRITE:   next_state_s = sb.mem_ack ? IDLE : WRITE;
      default: next_state_s = IDLE;
    endcase
  end

  // Entry storage and drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      valid_r <= '0;
      comm_r  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
        rb_r[i]   <= '0;
      end
    end else begin
      state_r <= next_state_s;
      valid_r <= valid_n_s;
      comm_r  <= comm_n_s;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_r[i] <= addr_n_s[i];
        data_r[i] <= data_n_s[i];
        rb_r[i]   <= rb_n_s[i];
      end
    end
  end

  // Registered dmem request, completion report and full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_r        <= '0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      done_valid_r <= 1'b0;
      done_rb_r    <= '0;
      sb_full_r    <= 1'b0;
    end else begin
      sb_full_r    <= &valid_n_s;
      mem_req_r    <= (next_state_s == WRITE);
      done_valid_r <= (state_r == WRITE) && sb.mem_ack;
      if ((state_r == IDLE) && pick_found_s) begin
        sel_r       <= pick_s;
        mem_addr_r  <= addr_n_s[pick_s];
        mem_wdata_r <= data_n_s[pick_s];
      end
      if ((state_r == WRITE) && sb.mem_ack) begin
        done_rb_r <= rb_r[sel_r];
      end
    end
  end

  assign sb.st_ack     = ack_s;
  assign sb.sb_full    = sb_full_r;
  assign sb.mem_req    = mem_req_r;
  assign sb.mem_addr   = mem_addr_r;
  assign sb.mem_wdata  = mem_wdata_r;
  assign sb.done_valid = done_valid_r;
  assign sb.done_rb    = done_rb_r;

`ifdef STORE_FWD_EN
  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  logic [CNT_W-1:0]     match_cnt_s;
  logic [WORD_SIZE-1:0] match_data_s;
  logic                 hit_s;

  // Forwarding CAM over valid entries; more than one match is a conflict.
  always_comb begin
    match_cnt_s  = '0;
    match_data_s = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      hit_s        = valid_r[i] && (addr_r[i] == sb.ld_addr);
      match_cnt_s  = match_cnt_s + CNT_W'(hit_s);
      match_data_s = hit_s ? data_r[i] : match_data_s;
    end
  end

  assign sb.fwd_hit      = (match_cnt_s == CNT_W'(1));
  assign sb.fwd_conflict = (match_cnt_s > CNT_W'(1));
  assign sb.fwd_data     = (match_cnt_s == CNT_W'(1)) ? match_data_s : '0;
`else
  assign sb.fwd_hit      = 1'b0;
  assign sb.fwd_conflict = 1'b0;
  assign sb.fwd_data     = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: arbitration vector table plus
// directed sequences, with a scoreboard for dmem writes and completions.
module tb_store_buffer;
  logic clk;
  logic reset;

  store_buffer_if #(.WORD_SIZE(32), .RB_INDEX(4), .STORER_NUM(2)) sb_if ();

  store_buffer #(.WORD_SIZE(32), .RB_INDEX(4), .STORER_NUM(2), .SB_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rb;
  } wr_t;

  typedef struct {
    logic [1:0] valid;
    logic       flush;
    logic [1:0] exp_ack;
    logic       exp_full;
  } vec_t;

  wr_t        exp_q[$];
  logic [3:0] done_q[$];
  vec_t       tbl[11];
  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  int ack_delay = 2;
  bit ack_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] r);
    sb_if.st_valid[s] = 1'b1;
    sb_if.st_addr[s*32 +: 32] = a;
    sb_if.st_data[s*32 +: 32] = d;
    sb_if.st_rb[s*4 +: 4] = r;
  endtask

  // Enqueue one store from storer 0 and check it is accepted immediately.
  task automatic enq0(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] r);
    offer(0, a, d, r);
    @(negedge clk);
    chk(name, sb_if.st_ack, 2'b01);
    tick();
    sb_if.st_valid[0] = 1'b0;
  endtask

  task automatic commit(input logic [3:0] r, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d; e.rb = r;
    exp_q.push_back(e);
    sb_if.commit_valid = 1'b1;
    sb_if.commit_rb = r;
    tick();
    sb_if.commit_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size() + done_q.size()), 64'd0);
  endtask

  // dmem model: acknowledges a pending request after ack_delay cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    sb_if.mem_ack = 1'b0;
    forever begin
      tick();
      if (sb_if.mem_ack) begin
        sb_if.mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (sb_if.mem_req && ack_en) begin
        if (wait_cnt >= ack_delay) sb_if.mem_ack = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: compare each accepted write and each completion report.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb_if.mem_req && sb_if.mem_ack) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(sb_if.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("mem_addr", 64'(sb_if.mem_addr), 64'(e.addr));
          chk("mem_wdata", 64'(sb_if.mem_wdata), 64'(e.data));
          done_q.push_back(e.rb);
        end
      end
      if (sb_if.done_valid) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'(sb_if.done_rb), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("done_rb", 64'(sb_if.done_rb), 64'(done_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bit acked;
    bit prev_ack;
    bit req_seen;
    tbl[0]  = '{2'b01, 1'b0, 2'b01, 1'b0};
    tbl[1]  = '{2'b10, 1'b0, 2'b10, 1'b0};
    tbl[2]  = '{2'b11, 1'b0, 2'b01, 1'b0};
    tbl[3]  = '{2'b00, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{2'b10, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{2'b01, 1'b0, 2'b01, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 2'b01, 1'b0};
    tbl[7]  = '{2'b10, 1'b0, 2'b10, 1'b0};
    tbl[8]  = '{2'b01, 1'b0, 2'b01, 1'b1};
    tbl[9]  = '{2'b11, 1'b0, 2'b00, 1'b1};
    tbl[10] = '{2'b00, 1'b1, 2'b00, 1'b0};

    reset = 1'b1;
    sb_if.st_valid = '0; sb_if.st_addr = '0; sb_if.st_data = '0; sb_if.st_rb = '0;
    sb_if.commit_valid = 1'b0; sb_if.commit_rb = '0; sb_if.flush = 1'b0;
    sb_if.ld_addr = 32'h0000_0100;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_st_ack", sb_if.st_ack, 2'b00);
    chk("rst_mem_req", sb_if.mem_req, 1'b0);
    chk("rst_mem_addr", sb_if.mem_addr, 32'h0);
    chk("rst_mem_wdata", sb_if.mem_wdata, 32'h0);
    chk("rst_done_valid", sb_if.done_valid, 1'b0);
    chk("rst_done_rb", sb_if.done_rb, 4'h0);
    chk("rst_sb_full", sb_if.sb_full, 1'b0);
    chk("rst_fwd", {sb_if.fwd_hit, sb_if.fwd_conflict, sb_if.fwd_data}, 34'h0);

    // Arbitration / full / flush vector table, starting empty, no commits.
    for (int r = 0; r < 11; r++) begin
      for (int j = 0; j < 2; j++) begin
        sb_if.st_valid[j] = tbl[r].valid[j];
        sb_if.st_addr[j*32 +: 32] = 32'h100 + 32'(r * 8 + j * 4);
        sb_if.st_data[j*32 +: 32] = 32'(r * 2 + j);
        sb_if.st_rb[j*4 +: 4] = 4'(r * 2 + j);
      end
      sb_if.flush = tbl[r].flush;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", r), sb_if.st_ack, tbl[r].exp_ack);
`ifndef STORE_FWD_EN
      chk($sformatf("tbl%0d_fwd_off", r), {sb_if.fwd_hit, sb_if.fwd_conflict, sb_if.fwd_data}, 34'h0);
`endif
      tick();
      chk($sformatf("tbl%0d_full", r), sb_if.sb_full, tbl[r].exp_full);
    end
    sb_if.st_valid = '0;
    sb_if.flush = 1'b0;

    // Single store, commit, drain with a two-cycle dmem ack.
    enq0("t1_ack", 32'h10, 32'hAB, 4'd3);
    commit(4'd3, 32'h10, 32'hAB);
    chk("t1_req_latency", sb_if.mem_req, 1'b1);
    chk("t1_req_addr", sb_if.mem_addr, 32'h10);
    wait_drain("t1_drain", 20);
    chk("t1_req_idle", sb_if.mem_req, 1'b0);
    chk("t1_empty", sb_if.sb_full, 1'b0);

    // Commit in the same cycle as the enqueue of that rb.
    offer(0, 32'h30, 32'h55, 4'd9);
    sb_if.commit_valid = 1'b1;
    sb_if.commit_rb = 4'd9;
    exp_q.push_back('{32'h30, 32'h55, 4'd9});
    tick();
    sb_if.st_valid[0] = 1'b0;
    sb_if.commit_valid = 1'b0;
    chk("same_cycle_commit_req", sb_if.mem_req, 1'b1);
    wait_drain("same_cycle_drain", 20);

    // Two storers in the same cycle: storer 0 first, storer 1 next cycle.
    offer(0, 32'h40, 32'h11, 4'd1);
    offer(1, 32'h44, 32'h22, 4'd2);
    @(negedge clk);
    chk("t2_ack_first", sb_if.st_ack, 2'b01);
    tick();
    sb_if.st_valid[0] = 1'b0;
    @(negedge clk);
    chk("t2_ack_second", sb_if.st_ack, 2'b10);
    tick();
    sb_if.st_valid[1] = 1'b0;
    commit(4'd2, 32'h44, 32'h22);
    wait_drain("t2_drain_rb2", 20);
    commit(4'd1, 32'h40, 32'h11);
    wait_drain("t2_drain_rb1", 20);

    // Full buffer holds a fifth store until an entry drains.
    for (int k = 0; k < 4; k++) enq0($sformatf("t3_fill%0d", k), 32'h200 + 32'(k * 4), 32'h300 + 32'(k), 4'(4 + k));
    chk("t3_full", sb_if.sb_full, 1'b1);
    offer(1, 32'h280, 32'h3FF, 4'd8);
    @(negedge clk);
    chk("t3_no_ack_full", sb_if.st_ack, 2'b00);
    tick();
    commit(4'd4, 32'h200, 32'h300);
    acked = 1'b0;
    prev_ack = 1'b0;
    for (int c = 0; c < 30 && !acked; c++) begin
      @(negedge clk);
      if (sb_if.st_ack[1]) begin
        acked = 1'b1;
        chk("t3_slot_reuse_next_cycle", prev_ack, 1'b1);
      end
      prev_ack = sb_if.mem_ack;
      tick();
    end
    chk("t3_fifth_acked", acked, 1'b1);
    sb_if.st_valid[1] = 1'b0;
    wait_drain("t3_drain_first", 20);
    for (int k = 1; k < 4; k++) begin
      commit(4'(4 + k), 32'h200 + 32'(k * 4), 32'h300 + 32'(k));
      wait_drain($sformatf("t3_drain%0d", k), 20);
    end
    commit(4'd8, 32'h280, 32'h3FF);
    wait_drain("t3_drain_fifth", 20);
    chk("t3_empty", sb_if.sb_full, 1'b0);

    // Flush keeps the committed (in-flight) store, drops the uncommitted one.
    w0 = writes_seen;
    enq0("t4_enq5", 32'h500, 32'h55, 4'd5);
    enq0("t4_enq6", 32'h504, 32'h66, 4'd6);
    commit(4'd5, 32'h500, 32'h55);
    sb_if.flush = 1'b1;
    tick();
    sb_if.flush = 1'b0;
    sb_if.commit_valid = 1'b1;
    sb_if.commit_rb = 4'd6;
    tick();
    sb_if.commit_valid = 1'b0;
    wait_drain("t4_drain", 20);
    repeat (8) tick();
    chk("t4_writes", 64'(writes_seen - w0), 64'd1);

    // Flush and commit in the same cycle: the commit wins.
    w0 = writes_seen;
    enq0("t4b_enq", 32'h600, 32'h77, 4'd10);
    sb_if.flush = 1'b1;
    commit(4'd10, 32'h600, 32'h77);
    sb_if.flush = 1'b0;
    wait_drain("t4b_drain", 20);
    chk("t4b_writes", 64'(writes_seen - w0), 64'd1);

    // Reset while a write waits for ack: request dropped, nothing replays.
    ack_en = 1'b0;
    for (int k = 0; k < 4; k++) enq0($sformatf("t5_fill%0d", k), 32'h700 + 32'(k * 4), 32'h800 + 32'(k), 4'(k));
    sb_if.commit_valid = 1'b1;
    sb_if.commit_rb = 4'd0;
    tick();
    sb_if.commit_valid = 1'b0;
    chk("t5_req_pending", sb_if.mem_req, 1'b1);
    chk("t5_full_before", sb_if.sb_full, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_req_dropped", sb_if.mem_req, 1'b0);
    chk("t5_full_cleared", sb_if.sb_full, 1'b0);
    exp_q.delete();
    done_q.delete();
    tick();
    tick();
    reset = 1'b0;
    ack_en = 1'b1;
    w0 = writes_seen;
    req_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      req_seen = req_seen | sb_if.mem_req | sb_if.done_valid;
    end
    chk("t5_no_replay", req_seen, 1'b0);
    for (int k = 0; k < 4; k++) enq0($sformatf("t5_refill%0d", k), 32'h900 + 32'(k * 4), 32'(k), 4'(k));
    chk("t5_refill_full", sb_if.sb_full, 1'b1);
    sb_if.flush = 1'b1;
    tick();
    sb_if.flush = 1'b0;
    chk("t5_flushed", sb_if.sb_full, 1'b0);
    chk("t5_writes", 64'(writes_seen - w0), 64'd0);

`ifdef STORE_FWD_EN
    // Forwarding lookup: single hit, conflict, miss.
    enq0("t6_enq_a", 32'h20, 32'h7, 4'd12);
    sb_if.ld_addr = 32'h20;
    #1;
    chk("t6_hit", {sb_if.fwd_hit, sb_if.fwd_conflict}, 2'b10);
    chk("t6_data", sb_if.fwd_data, 32'h7);
    enq0("t6_enq_b", 32'h20, 32'h9, 4'd13);
    #1;
    chk("t6_conflict", {sb_if.fwd_hit, sb_if.fwd_conflict}, 2'b01);
    sb_if.ld_addr = 32'h24;
    #1;
    chk("t6_miss", {sb_if.fwd_hit, sb_if.fwd_conflict, sb_if.fwd_data}, 34'h0);
    sb_if.flush = 1'b1;
    tick();
    sb_if.flush = 1'b0;
`else
    // Forwarding disabled: outputs stay zero even with a matching entry.
    enq0("t6_enq_a", 32'h20, 32'h7, 4'd12);
    sb_if.ld_addr = 32'h20;
    #1;
    chk("t6_fwd_off", {sb_if.fwd_hit, sb_if.fwd_conflict, sb_if.fwd_data}, 34'h0);
    sb_if.flush = 1'b1;
    tick();
    sb_if.flush = 1'b0;
`endif
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
